// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA raster generator and the game
// cores that consume its position and qualifier outputs.
package vga_pkg;

    localparam int CNT_W = 10;
    localparam int FC_W  = 8;

    typedef logic [CNT_W-1:0] coord_t;
    typedef logic [FC_W-1:0]  frame_cnt_t;

    // 640x480@60 with a 25 MHz pixel rate
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int MAX_TOTAL = 1 << CNT_W;

    function automatic int hTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int vTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter with enable, terminal-count flag and a
// registered sync output derived from the next count so it lines up with the position.
module timing_axis_counter
    import vga_pkg::*;
#(
    parameter int   TOTAL      = 800,
    parameter int   SYNC_START = 656,
    parameter int   SYNC_LEN   = 96,
    parameter logic POL        = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t count,
    output coord_t nextCount,
    output logic   termCount,
    output logic   syncOut
);

    localparam coord_t LAST       = CNT_W'(TOTAL - 1);
    localparam coord_t SYNC_FIRST = CNT_W'(SYNC_START);
    localparam coord_t SYNC_LAST  = CNT_W'(SYNC_START + SYNC_LEN - 1);

    logic syncNext;

    always_comb begin
        termCount = (count == LAST);
        nextCount = count;
        if (en) begin
            nextCount = termCount ? '0 : count + CNT_W'(1);
        end
        syncNext = ((nextCount >= SYNC_FIRST) && (nextCount <= SYNC_LAST)) ? POL : ~POL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            syncOut <= ~POL;
        end else begin
            count   <= nextCount;
            syncOut <= syncNext;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: position counters, display qualifier, sync pulses,
// line/frame strobes and a frame counter, all registered with zero skew.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pix_ce,
    output coord_t       counter_x,
    output coord_t       counter_y,
    output logic         in_display_area,
    output logic         vga_h_sync,
    output logic         vga_v_sync,
    output logic         line_start,
    output logic         frame_start,
    output frame_cnt_t   frame_count
);

    localparam int H_TOTAL = hTotal(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vTotal(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_ACT_C = CNT_W'(H_ACTIVE);
    localparam coord_t V_ACT_C = CNT_W'(V_ACTIVE);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : gBadTotal
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
    end
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : gBadPorch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    coord_t     hCount, hNext, vCount, vNext;
    logic       hTerm, vTerm, hSync, vSync;
    logic       lineWrap, frameWrap;
    logic       displayQ, lineQ, frameQ;
    frame_cnt_t frameCnt;

    // pix_ce is a plain enable, not a handshake: every clk with pix_ce=1 is one pixel
    // step, and line_start/frame_start are single-clk strobes marking the step that
    // produced the wrap; they are never raised on a pix_ce=0 clk.
    assign lineWrap  = pix_ce & hTerm;
    assign frameWrap = lineWrap & vTerm;

    timing_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .POL        (H_POL)
    ) hAxis (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pix_ce),
        .count     (hCount),
        .nextCount (hNext),
        .termCount (hTerm),
        .syncOut   (hSync)
    );

    // The vertical axis steps only on the pixel that ends a line, so vsync spans whole lines.
    timing_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .POL        (V_POL)
    ) vAxis (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (lineWrap),
        .count     (vCount),
        .nextCount (vNext),
        .termCount (vTerm),
        .syncOut   (vSync)
    );

    // The display qualifier resets low even though (0,0) is visible; it only goes
    // live once the first enabled pixel step has happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            displayQ <= 1'b0;
            lineQ    <= 1'b0;
            frameQ   <= 1'b0;
            frameCnt <= '0;
        end else begin
            lineQ  <= lineWrap;
            frameQ <= frameWrap;
            if (pix_ce) begin
                displayQ <= (hNext < H_ACT_C) && (vNext < V_ACT_C);
            end
            if (frameWrap) begin
                frameCnt <= frameCnt + FC_W'(1);
            end
        end
    end

    assign counter_x       = hCount;
    assign counter_y       = vCount;
    assign in_display_area = displayQ;
    assign vga_h_sync      = hSync;
    assign vga_v_sync      = vSync;
    assign line_start      = lineQ;
    assign frame_start     = frameQ;
    assign frame_count     = frameCnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-timing instances (both sync polarities) and one
// default 640x480 instance, checked every clk against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int W = 33;

    localparam int S_HA = 8, S_HFP = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 4, S_VFP = 1, S_VS = 2, S_VB = 1;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VB;
    localparam int S_FRAME = S_HT * S_VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_ce = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] aX, aY, bX, bY, cX, cY;
    logic [7:0] aF, bF, cF;
    logic aDa, aHs, aVs, aLs, aFs;
    logic bDa, bHs, bVs, bLs, bFs;
    logic cDa, cHs, cVs, cLs, cFs;

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VB),
        .H_POL(1'b0), .V_POL(1'b0)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .counter_x(aX), .counter_y(aY), .in_display_area(aDa),
        .vga_h_sync(aHs), .vga_v_sync(aVs), .line_start(aLs),
        .frame_start(aFs), .frame_count(aF)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VB),
        .H_POL(1'b1), .V_POL(1'b1)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .counter_x(bX), .counter_y(bY), .in_display_area(bDa),
        .vga_h_sync(bHs), .vga_v_sync(bVs), .line_start(bLs),
        .frame_start(bFs), .frame_count(bF)
    );

    vga_timing_gen dutC (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
        .counter_x(cX), .counter_y(cY), .in_display_area(cDa),
        .vga_h_sync(cHs), .vga_v_sync(cVs), .line_start(cLs),
        .frame_start(cFs), .frame_count(cF)
    );

    logic [W-1:0] actA, actB, actC;
    assign actA = {aX, aY, aF, aDa, aHs, aVs, aLs, aFs};
    assign actB = {bX, bY, bF, bDa, bHs, bVs, bLs, bFs};
    assign actC = {cX, cY, cF, cDa, cHs, cVs, cLs, cFs};

    logic [W-1:0] expAQ[$];
    logic [W-1:0] expBQ[$];
    logic [W-1:0] expCQ[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    longint tick = 0;
    bit advanced = 1'b0;

    // Raster model: position is simply the number of enabled steps since reset.
    function automatic logic [W-1:0] model(input int ha, input int hfp, input int hs, input int hb,
                                           input int va, input int vfp, input int vs, input int vb,
                                           input logic hpol, input logic vpol,
                                           input longint tt, input bit adv);
        int ht, vt, x, y, f;
        logic da, hsy, vsy, ls, fs;
        ht = ha + hfp + hs + hb;
        vt = va + vfp + vs + vb;
        x = int'(tt % ht);
        y = int'((tt / ht) % vt);
        f = int'((tt / (ht * vt)) % 256);
        da = (tt > 0) && (x < ha) && (y < va);
        hsy = (x >= ha + hfp && x < ha + hfp + hs) ? hpol : ~hpol;
        vsy = (y >= va + vfp && y < va + vfp + vs) ? vpol : ~vpol;
        ls = adv && (x == 0);
        fs = ls && (y == 0);
        return {10'(x), 10'(y), 8'(f), da, hsy, vsy, ls, fs};
    endfunction

    function automatic logic [W-1:0] expA(input longint tt, input bit adv);
        return model(S_HA, S_HFP, S_HS, S_HB, S_VA, S_VFP, S_VS, S_VB, 1'b0, 1'b0, tt, adv);
    endfunction

    function automatic logic [W-1:0] expB(input longint tt, input bit adv);
        return model(S_HA, S_HFP, S_HS, S_HB, S_VA, S_VFP, S_VS, S_VB, 1'b1, 1'b1, tt, adv);
    endfunction

    function automatic logic [W-1:0] expC(input longint tt, input bit adv);
        return model(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, tt, adv);
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h (x=%0d y=%0d) expected=%h (x=%0d y=%0d)",
                     name, cyc, got, got[32:23], got[22:13], exp, exp[32:23], exp[22:13]);
        end
    endtask

    task automatic pushExpected();
        expAQ.push_back(expA(tick, advanced));
        expBQ.push_back(expB(tick, advanced));
        expCQ.push_back(expC(tick, advanced));
    endtask

    // One clk: the model takes the edge with the inputs that were in effect, then the
    // next inputs are driven and the expected outputs for this interval are queued.
    task automatic step(input logic ceNext, input logic rstNext);
        @(posedge clk);
        if (rst_n && pix_ce) begin
            tick++;
            advanced = 1'b1;
        end else begin
            advanced = 1'b0;
        end
        #1;
        pix_ce = ceNext;
        rst_n = rstNext;
        if (!rst_n) begin
            tick = 0;
            advanced = 1'b0;
        end
        pushExpected();
    endtask

    // Reset dropped between edges must clear the outputs without waiting for a clk.
    task automatic asyncResetMidLine();
        int n;
        n = 0;
        while (int'(tick % 800) != 300 && n < 2000) begin
            step(1'b1, 1'b1);
            n++;
        end
        check("reach_x300", W'(n < 2000), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        tick = 0;
        advanced = 1'b0;
        check("async_reset_c", actC, expC(0, 1'b0));
        check("async_reset_a", actA, expA(0, 1'b0));
        void'(expAQ.pop_back());
        void'(expBQ.pop_back());
        void'(expCQ.pop_back());
        pushExpected();
    endtask

    int lsSince = 0;
    bit seenFrame = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (expAQ.size() > 0) check("dutA", actA, expAQ.pop_front());
        if (expBQ.size() > 0) check("dutB_pol", actB, expBQ.pop_front());
        if (expCQ.size() > 0) check("dutC_640", actC, expCQ.pop_front());
        if (!rst_n) begin
            lsSince = 0;
            seenFrame = 1'b0;
        end else begin
            if (aLs) lsSince++;
            if (aFs) begin
                if (seenFrame) check("lines_per_frame", W'(lsSince), W'(S_VT));
                lsSince = 0;
                seenFrame = 1'b1;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        pix_ce = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (257 * S_FRAME + 20) step(1'b1, 1'b1);
        for (int i = 0; i < 4 * S_FRAME; i++) step(i[0] ? 1'b1 : 1'b0, 1'b1);
        repeat (3000) step(1'($urandom_range(0, 1)), 1'b1);
        asyncResetMidLine();
        repeat (3) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (1700) step(1'b1, 1'b1);
        repeat (500) step(1'($urandom_range(0, 1)), 1'b1);
        @(negedge clk);
        #1;
        check("queue_drain", W'(expAQ.size() + expBQ.size() + expCQ.size()), W'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
